// File: rtl/uart_rx_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// uart_rx_sequencer_pkg
//   Shared definitions for the serial-port receive path: FSM state encodings,
//   frame geometry in terms of the bit identification count (BIC), the
//   mid-bit sample point of the bit sample count (BSC), and the 2-of-3
//   majority helper used by the optional rx noise filter (RX_MAJORITY_EN).
// ----------------------------------------------------------------------------
package uart_rx_sequencer_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned START_IDX  = 0;
    localparam int unsigned STOP_IDX   = DATA_BITS + 1;
    localparam logic [3:0]  MID_SAMPLE = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    function automatic logic majority3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/uart_rx_sequencer_shifter.sv
// ----------------------------------------------------------------------------
// uart_rx_shifter
//   Serial-in shift register for the received data bits. Bits arrive LSB
//   first, so each new bit enters at the MSB and moves toward bit 0.
// Ports
//   clk        in   system clock
//   reset      in   asynchronous active-high reset (clears the register)
//   shift_en_i in   shift one bit in this cycle
//   bit_i      in   serial data bit
//   data_o     out  current register contents
// ----------------------------------------------------------------------------
module uart_rx_shifter #(
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 shift_en_i,
    input  logic                 bit_i,
    output logic [DATA_BITS-1:0] data_o
);

    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;

    always_comb begin
        shift_d = shift_q;
        if (shift_en_i) begin
            shift_d = {bit_i, shift_q[DATA_BITS-1:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign data_o = shift_q;

endmodule

// File: rtl/uart_rx_sequencer.sv
// ----------------------------------------------------------------------------
// uart_rx_sequencer
//   Receive sequencer for the serial port. Detects the start edge, enables
//   the external bit/sample counter, samples data bits on its mid-bit strobe,
//   checks the stop bit and presents the character through a valid/ack
//   buffer with overrun and framing-error reporting.
// Configuration
//   RX_MAJORITY_EN : when defined, rx passes through a 2-of-3 majority filter
//                    over the last three clock samples (adds 2 clk latency).
// Ports
//   clk         in   system clock
//   reset       in   asynchronous active-high reset
//   rx          in   synchronised serial input, idle high
//   cnt_enable  out  bit counter enable; low holds the counter cleared
//   bic         in   bit identification count from the counter
//   sr_clk      in   one-cycle mid-bit sample strobe
//   char_rcvd   in   end-of-frame strobe
//   data_out    out  received character, stable while data_valid is high
//   data_valid  out  character available
//   data_ack    in   consumer takes the character (only when data_valid)
//   frame_err   out  one-cycle pulse: stop bit low, character discarded
//   overrun     out  sticky: new character overwrote an unacknowledged one
// ----------------------------------------------------------------------------
module uart_rx_sequencer #(
    parameter int unsigned DATA_BITS = uart_rx_sequencer_pkg::DATA_BITS,
    parameter int unsigned STOP_IDX  = uart_rx_sequencer_pkg::STOP_IDX
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic                 cnt_enable,
    input  logic [3:0]           bic,
    input  logic                 sr_clk,
    input  logic                 char_rcvd,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ack,
    output logic                 frame_err,
    output logic                 overrun
);

    import uart_rx_sequencer_pkg::*;

    localparam logic [3:0] START_BIC     = 4'(START_IDX);
    localparam logic [3:0] STOP_BIC      = 4'(STOP_IDX);
    localparam logic [3:0] LAST_DATA_BIC = 4'(DATA_BITS);

    rx_state_e            state_q;
    logic                 cnt_en_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 ovr_q;
    logic                 stop_bit_q;

    logic                 rx_s;
    logic                 shift_en;
    logic [DATA_BITS-1:0] shift_data;

`ifdef RX_MAJORITY_EN
    logic [2:0] hist_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q <= '1;
        end else begin
            hist_q <= {hist_q[1:0], rx};
        end
    end

    assign rx_s = majority3(hist_q);
`else
    assign rx_s = rx;
`endif

    assign shift_en = (state_q == ST_DATA) && sr_clk &&
                      (bic != 4'd0) && (bic <= LAST_DATA_BIC);

    uart_rx_shifter #(
        .DATA_BITS (DATA_BITS)
    ) u_shifter (
        .clk        (clk),
        .reset      (reset),
        .shift_en_i (shift_en),
        .bit_i      (rx_s),
        .data_o     (shift_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_en_q   <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
            stop_bit_q <= 1'b0;
        end else begin
            ferr_q <= 1'b0;

            if (data_ack && valid_q) begin
                valid_q <= 1'b0;
                ovr_q   <= 1'b0;
            end

            // Buffer load below is written after the ack so it wins on a tie.
            case (state_q)
                ST_IDLE: begin
                    cnt_en_q <= 1'b0;
                    if (!rx_s) begin
                        state_q  <= ST_START;
                        cnt_en_q <= 1'b1;
                    end
                end
                ST_START: begin
                    if (sr_clk && (bic == START_BIC)) begin
                        if (rx_s) begin
                            state_q  <= ST_IDLE;
                            cnt_en_q <= 1'b0;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (sr_clk && (bic == STOP_BIC)) begin
                        state_q    <= ST_STOP;
                        stop_bit_q <= rx_s;
                    end
                end
                ST_STOP: begin
                    if (char_rcvd) begin
                        state_q  <= ST_IDLE;
                        cnt_en_q <= 1'b0;
                        if (stop_bit_q) begin
                            data_q  <= shift_data;
                            valid_q <= 1'b1;
                            ovr_q   <= valid_q && !data_ack;
                        end else begin
                            ferr_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    cnt_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign cnt_enable = cnt_en_q;
    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_sequencer
//   Drives uart_rx_sequencer together with a model of the existing bit
//   counter (16 clk per bit, BIC wraps after the stop bit). A table of frames
//   covers reception, framing error, overrun and ack/load collision; hand
//   sequences cover the start glitch, back-to-back frames and mid-frame reset.
// ----------------------------------------------------------------------------
module tb_uart_rx_sequencer;
    import uart_rx_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       cnt_enable;
    logic [3:0] bic;
    logic [3:0] bsc;
    logic       sr_clk;
    logic       char_rcvd;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ack;
    logic       frame_err;
    logic       overrun;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    uart_rx_sequencer #(
        .DATA_BITS (8),
        .STOP_IDX  (9)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .cnt_enable (cnt_enable),
        .bic        (bic),
        .sr_clk     (sr_clk),
        .char_rcvd  (char_rcvd),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ack   (data_ack),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    // Bit counter model: held clear while disabled, 16 samples per bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bsc <= 4'd0;
            bic <= 4'd0;
        end else if (!cnt_enable) begin
            bsc <= 4'd0;
            bic <= 4'd0;
        end else if (bsc == 4'd15) begin
            bsc <= 4'd0;
            bic <= (bic == 4'd9) ? 4'd0 : bic + 4'd1;
        end else begin
            bsc <= bsc + 4'd1;
        end
    end

    assign sr_clk    = cnt_enable && (bsc == MID_SAMPLE);
    assign char_rcvd = cnt_enable && (bic == 4'd9) && (bsc == 4'd15);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Drives one full frame, 16 clk per bit; call at a negedge.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < 16; c++) begin
                rx = f[0];
                @(negedge clk);
            end
            f = {1'b1, f[9:1]};
        end
        rx = 1'b1;
    endtask

    task automatic wait_char();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (char_rcvd) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("char_rcvd_seen", {31'd0, ok}, 32'd1);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       ack_load;
        logic       ack_after;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_ferr;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs[11];
    logic prev_v;

    initial begin
        begin : watchdog
            #1_000_000;
            $display("FAIL watchdog: simulation time limit reached");
            $fatal(1);
        end
    end

    initial begin
        reset    = 1'b1;
        rx       = 1'b1;
        data_ack = 1'b0;

        //            d      stop ackL ackA  v     data   ferr  ovr
        vecs[0]  = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1]  = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2]  = '{8'h55, 1'b1, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0};
        vecs[3]  = '{8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0};
        vecs[4]  = '{8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b1};
        vecs[5]  = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};
        vecs[6]  = '{8'h99, 1'b1, 1'b1, 1'b1, 1'b1, 8'h99, 1'b0, 1'b0};
        vecs[7]  = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[8]  = '{8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0};
        vecs[9]  = '{8'h81, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0};
        vecs[10] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_cnt_enable", {31'd0, cnt_enable}, 32'd0);
        chk("rst_data_out",   {24'd0, data_out},   32'd0);
        chk("rst_data_valid", {31'd0, data_valid}, 32'd0);
        chk("rst_frame_err",  {31'd0, frame_err},  32'd0);
        chk("rst_overrun",    {31'd0, overrun},    32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_cnt_enable", {31'd0, cnt_enable}, 32'd0);

        // Start glitch: 4 clk low, rejected at the bic==0 sample strobe
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        chk("glitch_enabled",  {31'd0, cnt_enable}, 32'd1);
        chk("glitch_strobe",   {31'd0, sr_clk},     32'd1);
        chk("glitch_bic",      {28'd0, bic},        32'd0);
        @(negedge clk);
        chk("glitch_abort",    {31'd0, cnt_enable}, 32'd0);
        repeat (20) @(negedge clk);
        chk("glitch_no_valid", {31'd0, data_valid}, 32'd0);
        chk("glitch_bic_clr",  {28'd0, bic},        32'd0);

        // Table of frames
        prev_v = 1'b0;
        for (int i = 0; i < 11; i++) begin
            send_frame(vecs[i].d, vecs[i].stop);
            wait_char();
            chk($sformatf("v%0d_valid_before", i), {31'd0, data_valid}, {31'd0, prev_v});
            data_ack = vecs[i].ack_load;
            @(negedge clk);
            data_ack = 1'b0;
            chk($sformatf("v%0d_valid", i), {31'd0, data_valid}, {31'd0, vecs[i].exp_valid});
            if (vecs[i].exp_valid)
                chk($sformatf("v%0d_data", i), {24'd0, data_out}, {24'd0, vecs[i].exp_data});
            chk($sformatf("v%0d_ferr", i), {31'd0, frame_err}, {31'd0, vecs[i].exp_ferr});
            chk($sformatf("v%0d_ovr", i),  {31'd0, overrun},   {31'd0, vecs[i].exp_ovr});
            chk($sformatf("v%0d_cnt_off", i), {31'd0, cnt_enable}, 32'd0);
            @(negedge clk);
            chk($sformatf("v%0d_ferr_end", i), {31'd0, frame_err}, 32'd0);
            prev_v = vecs[i].exp_valid;
            if (vecs[i].ack_after) begin
                data_ack = 1'b1;
                @(negedge clk);
                data_ack = 1'b0;
                chk($sformatf("v%0d_ack_valid", i), {31'd0, data_valid}, 32'd0);
                chk($sformatf("v%0d_ack_ovr", i),   {31'd0, overrun},    32'd0);
                prev_v = 1'b0;
            end else begin
                data_ack = 1'b1;
                if (data_valid) data_ack = 1'b0;
                @(negedge clk);
                data_ack = 1'b0;
                chk($sformatf("v%0d_hold_valid", i), {31'd0, data_valid}, {31'd0, prev_v});
            end
            repeat (3) @(negedge clk);
        end

        // Back-to-back frames, no ack: second start accepted right after STOP
        send_frame(8'h3B, 1'b1);
        send_frame(8'h6D, 1'b1);
        wait_char();
        @(negedge clk);
        chk("b2b_data",  {24'd0, data_out},   32'h6D);
        chk("b2b_valid", {31'd0, data_valid}, 32'd1);
        chk("b2b_ovr",   {31'd0, overrun},    32'd1);
        repeat (2) @(negedge clk);

        // Reset at bic==4 mid-frame, with a buffered character pending
        begin
            logic [9:0] f;
            logic       found;
            f     = {1'b1, 8'h12, 1'b0};
            found = 1'b0;
            for (int c = 0; c < 160; c++) begin
                rx = f[0];
                @(negedge clk);
                if (bic == 4'd4) begin
                    found = 1'b1;
                    break;
                end
                if ((c % 16) == 15) f = {1'b1, f[9:1]};
            end
            chk("mid_bic4_reached", {31'd0, found}, 32'd1);
        end
        reset = 1'b1;
        #1;
        chk("mid_rst_cnt_enable", {31'd0, cnt_enable}, 32'd0);
        chk("mid_rst_data_out",   {24'd0, data_out},   32'd0);
        chk("mid_rst_valid",      {31'd0, data_valid}, 32'd0);
        chk("mid_rst_overrun",    {31'd0, overrun},    32'd0);
        chk("mid_rst_frame_err",  {31'd0, frame_err},  32'd0);
        @(negedge clk);
        reset = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(8'h7E, 1'b1);
        wait_char();
        @(negedge clk);
        chk("post_rst_data",  {24'd0, data_out},   32'h7E);
        chk("post_rst_valid", {31'd0, data_valid}, 32'd1);
        chk("post_rst_ovr",   {31'd0, overrun},    32'd0);
        chk("post_rst_ferr",  {31'd0, frame_err},  32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
